// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, flush, bubble/hold counters and sticky stall watchdog.
// Latency 1 cycle on LOAD; backpressure is the global stall vector (HOLD keeps the payload, BUBBLE inserts NOP).
module pipe_stage_reg #(
    parameter int                DATA_W    = 110,
    parameter logic [DATA_W-1:0] NOP_VAL   = {DATA_W{1'b0}},
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 3,
    parameter int                CNT_W     = 16,
    parameter int                TMO_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [15:0]        hold_cnt,
    output logic               stall_tmo
);

    logic s_up;
    logic s_dn;
    logic unused_stall;

    assign s_up         = stall[STAGE];
    assign unused_stall = ^stall;

    // The last stage has no downstream stall bit to observe.
    generate
        if (STAGE == STALL_W - 1) begin : g_top_stage
            assign s_dn = 1'b0;
        end else begin : g_mid_stage
            assign s_dn = stall[STAGE+1];
        end
    endgenerate

    logic [CNT_W-1:0] bubble_nxt;
    logic [15:0]      hold_nxt;

    assign bubble_nxt = (&bubble_cnt) ? bubble_cnt : bubble_cnt + CNT_W'(1);
    assign hold_nxt   = (&hold_cnt)   ? hold_cnt   : hold_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= NOP_VAL;
            out_valid  <= 1'b0;
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            stall_tmo  <= 1'b0;
        end else if (flush) begin
            out_data  <= NOP_VAL;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            stall_tmo <= 1'b0;
        end else if (s_up && !s_dn) begin
            out_data   <= NOP_VAL;
            out_valid  <= 1'b0;
            bubble_cnt <= bubble_nxt;
            hold_cnt   <= '0;
        end else if (!s_up) begin
            out_data  <= in_data;
            out_valid <= in_valid;
            hold_cnt  <= '0;
        end else begin
            hold_cnt <= hold_nxt;
            // Compare against the post-increment count so the flag rises on the limiting edge.
            if (hold_nxt == 16'(TMO_LIMIT)) begin
                stall_tmo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   stall_a;
    logic [109:0] in_data_a;
    logic         in_valid_a;
    logic [109:0] out_data_a;
    logic         out_valid_a;
    logic [15:0]  bubble_cnt_a;
    logic [15:0]  hold_cnt_a;
    logic         stall_tmo_a;

    logic [5:0]   stall_b;
    logic [7:0]   in_data_b;
    logic         in_valid_b;
    logic [7:0]   out_data_b;
    logic         out_valid_b;
    logic [3:0]   bubble_cnt_b;
    logic [15:0]  hold_cnt_b;
    logic         stall_tmo_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           b;
        logic [109:0] d;
        logic         v;
        logic [15:0]  bc;
        logic [15:0]  hc;
        logic         t;
    } exp_t;

    exp_t q[$];

    pipe_stage_reg #(
        .DATA_W(110), .STALL_W(6), .STAGE(3), .CNT_W(16), .TMO_LIMIT(4)
    ) dut_a (
        .clk(clk), .rst(rst), .stall(stall_a), .flush(flush),
        .in_data(in_data_a), .in_valid(in_valid_a),
        .out_data(out_data_a), .out_valid(out_valid_a),
        .bubble_cnt(bubble_cnt_a), .hold_cnt(hold_cnt_a), .stall_tmo(stall_tmo_a)
    );

    pipe_stage_reg #(
        .DATA_W(8), .STALL_W(6), .STAGE(5), .CNT_W(4), .TMO_LIMIT(255)
    ) dut_b (
        .clk(clk), .rst(rst), .stall(stall_b), .flush(flush),
        .in_data(in_data_b), .in_valid(in_valid_b),
        .out_data(out_data_b), .out_valid(out_valid_b),
        .bubble_cnt(bubble_cnt_b), .hold_cnt(hold_cnt_b), .stall_tmo(stall_tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one edge on DUT A and queue the hand-computed result.
    task automatic cyc_a(input logic [5:0] s, input logic f, input logic [109:0] d, input logic v,
                         input logic [109:0] ed, input logic ev, input int ebc, input int ehc,
                         input logic et);
        exp_t e;
        @(negedge clk);
        stall_a = s; flush = f; in_data_a = d; in_valid_a = v;
        e.b = 1'b0; e.d = ed; e.v = ev; e.bc = 16'(ebc); e.hc = 16'(ehc); e.t = et;
        q.push_back(e);
    endtask

    task automatic cyc_b(input logic [5:0] s, input logic [7:0] d, input logic v,
                         input logic [7:0] ed, input logic ev, input int ebc);
        exp_t e;
        @(negedge clk);
        stall_b = s; flush = 1'b0; in_data_b = d; in_valid_b = v;
        e.b = 1'b1; e.d = 110'(ed); e.v = ev; e.bc = 16'(ebc); e.hc = 16'd0; e.t = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: outputs are presented every edge; compare one queued expectation per edge.
    initial begin
        exp_t e;
        int   n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n++;
                if (!e.b) begin
                    chk($sformatf("a%0d out_data", n),   128'(out_data_a),   128'(e.d));
                    chk($sformatf("a%0d out_valid", n),  128'(out_valid_a),  128'(e.v));
                    chk($sformatf("a%0d bubble_cnt", n), 128'(bubble_cnt_a), 128'(e.bc));
                    chk($sformatf("a%0d hold_cnt", n),   128'(hold_cnt_a),   128'(e.hc));
                    chk($sformatf("a%0d stall_tmo", n),  128'(stall_tmo_a),  128'(e.t));
                end else begin
                    chk($sformatf("b%0d out_data", n),   128'(out_data_b),   128'(e.d));
                    chk($sformatf("b%0d out_valid", n),  128'(out_valid_b),  128'(e.v));
                    chk($sformatf("b%0d bubble_cnt", n), 128'(bubble_cnt_b), 128'(e.bc));
                    chk($sformatf("b%0d hold_cnt", n),   128'(hold_cnt_b),   128'(e.hc));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        stall_a = '0; in_data_a = '1; in_valid_a = 1'b1;
        stall_b = '0; in_data_b = '1; in_valid_b = 1'b1;

        // Reset value visible before the first clock edge.
        #2;
        chk("rst_noedge out_data",   128'(out_data_a),   128'd0);
        chk("rst_noedge out_valid",  128'(out_valid_a),  128'd0);
        chk("rst_noedge bubble_cnt", 128'(bubble_cnt_a), 128'd0);
        chk("rst_noedge hold_cnt",   128'(hold_cnt_a),   128'd0);
        chk("rst_noedge stall_tmo",  128'(stall_tmo_a),  128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk out_data",  128'(out_data_a),  128'd0);
        chk("rst_clk out_valid", 128'(out_valid_a), 128'd0);
        chk("rst_clk b_out_data", 128'(out_data_b), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load, then load with in_valid=0.
        cyc_a(6'b000000, 0, 'h2A5, 1, 'h2A5, 1, 0, 0, 0);
        cyc_a(6'b000000, 0, 'h111, 0, 'h111, 0, 0, 0, 0);
        // Bubbles.
        cyc_a(6'b000000, 0, 'h55, 1, 'h55, 1, 0, 0, 0);
        cyc_a(6'b001000, 0, 'h99, 1, 'h0, 0, 1, 0, 0);
        cyc_a(6'b001000, 0, 'h99, 1, 'h0, 0, 2, 0, 0);
        cyc_a(6'b001000, 0, 'h99, 1, 'h0, 0, 3, 0, 0);
        // Holds; watchdog trips on the 4th.
        cyc_a(6'b000000, 0, 'h77, 1, 'h77, 1, 3, 0, 0);
        cyc_a(6'b011000, 0, 'h88, 0, 'h77, 1, 3, 1, 0);
        cyc_a(6'b011000, 0, 'h88, 0, 'h77, 1, 3, 2, 0);
        cyc_a(6'b011000, 0, 'h88, 0, 'h77, 1, 3, 3, 0);
        cyc_a(6'b011000, 0, 'h88, 0, 'h77, 1, 3, 4, 1);
        cyc_a(6'b011000, 0, 'h88, 0, 'h77, 1, 3, 5, 1);
        // Flush beats an all-ones stall vector.
        cyc_a(6'b111111, 1, 'h88, 1, 'h0, 0, 3, 0, 0);
        cyc_a(6'b111111, 0, 'h88, 1, 'h0, 0, 3, 1, 0);
        // Watchdog stays set through LOAD and BUBBLE, cleared by flush.
        cyc_a(6'b000000, 0, 'hAB, 1, 'hAB, 1, 3, 0, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hAB, 1, 3, 1, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hAB, 1, 3, 2, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hAB, 1, 3, 3, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hAB, 1, 3, 4, 1);
        cyc_a(6'b000000, 0, 'hCD, 1, 'hCD, 1, 3, 0, 1);
        cyc_a(6'b001000, 0, 'hCD, 1, 'h0, 0, 4, 0, 1);
        cyc_a(6'b000000, 1, 'hFF, 1, 'h0, 0, 4, 0, 0);
        // Three holds then load: no trip.
        cyc_a(6'b000000, 0, 'hEE, 1, 'hEE, 1, 4, 0, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hEE, 1, 4, 1, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hEE, 1, 4, 2, 0);
        cyc_a(6'b011000, 0, 'h0, 0, 'hEE, 1, 4, 3, 0);
        cyc_a(6'b000000, 0, 'h12, 0, 'h12, 0, 4, 0, 0);
        // Wide payload passes every bit.
        cyc_a(6'b000000, 0, {110{1'b1}}, 1, {110{1'b1}}, 1, 4, 0, 0);
        cyc_a(6'b011000, 0, 'h0, 0, {110{1'b1}}, 1, 4, 1, 0);
        cyc_a(6'b011000, 0, 'h0, 0, {110{1'b1}}, 1, 4, 2, 0);

        // Reset mid-hold takes effect without an edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_midhold out_data",   128'(out_data_a),   128'd0);
        chk("rst_midhold out_valid",  128'(out_valid_a),  128'd0);
        chk("rst_midhold bubble_cnt", 128'(bubble_cnt_a), 128'd0);
        chk("rst_midhold hold_cnt",   128'(hold_cnt_a),   128'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc_a(6'b000000, 0, 'h34, 1, 'h34, 1, 0, 0, 0);

        // Top stage: s_dn is absent, so every stalled edge is a bubble; counter saturates at 15.
        cyc_b(6'b000000, 8'h5A, 1, 8'h5A, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc_b(6'b111111, 8'hC3, 1, 8'h00, 0, (i > 15) ? 15 : i);
        end
        cyc_b(6'b000000, 8'h3C, 1, 8'h3C, 1, 15);

        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            tests++;
            if (q.size() > 0) begin
                fails++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
